// File: rtl/led_fade_pwm_pkg.sv
// ----------------------------------------------------------------------------
// led_fade_pwm_pkg : shared board constants for the LED fade/PWM stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package led_fade_pwm_pkg;

   localparam int unsigned C_N_LED        = 4;
   localparam int unsigned C_PWM_BITS     = 8;
   localparam int unsigned C_DECAY_FRAMES = 64;
   localparam int unsigned C_DECAY_STEP   = 16;
   localparam int unsigned C_ACTIVE_LOW   = 1;

   // Counter width for 0..n-1, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/led_fade_pwm_if.sv
// ----------------------------------------------------------------------------
// led_fade_pwm_if : pattern/enable in, LED pins and frame strobe out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface led_fade_pwm_if
   import led_fade_pwm_pkg::*;
#(
   parameter int unsigned N_LED = C_N_LED
);
   logic [N_LED-1:0] pattern_i;
   logic             en_i;
   logic [N_LED-1:0] led_o;
   logic             frame_o;

   modport master (output pattern_i, output en_i, input led_o, input frame_o);
   modport slave  (input pattern_i, input en_i, output led_o, output frame_o);
endinterface

`default_nettype wire

// File: rtl/led_fade_channel.sv
// ----------------------------------------------------------------------------
// led_fade_channel : one LED's brightness level, frame duty latch and PWM pin
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module led_fade_channel
   import led_fade_pwm_pkg::*;
#(
   parameter int unsigned PWM_BITS   = C_PWM_BITS,
   parameter int unsigned DECAY_STEP = C_DECAY_STEP,
   parameter int unsigned ACTIVE_LOW = C_ACTIVE_LOW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pattern_i,
   input  logic                en_i,
   input  logic [PWM_BITS-1:0] pwm_cnt_i,
   input  logic                pwm_wrap_i,
   input  logic                decay_tick_i,
   output logic                led_o
);

   localparam logic [PWM_BITS-1:0] c_max  = '1;
   localparam logic [PWM_BITS-1:0] c_step = PWM_BITS'(DECAY_STEP);
   localparam logic                c_dark = (ACTIVE_LOW != 0);

   logic [PWM_BITS-1:0] level_q, level_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                led_q, led_d;

   always_comb begin
      level_d = level_q;
      if (pattern_i) begin
         level_d = c_max;
      end else if (decay_tick_i) begin
         level_d = (level_q < c_step) ? '0 : level_q - c_step;
      end
      // Duty takes the level from before this cycle's update, so a whole frame sees one value.
      duty_d = pwm_wrap_i ? level_q : duty_q;
      led_d  = (en_i && (pwm_cnt_i < duty_q)) ^ c_dark;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= '0;
         duty_q  <= '0;
         led_q   <= c_dark;
      end else begin
         level_q <= level_d;
         duty_q  <= duty_d;
         led_q   <= led_d;
      end
   end

   assign led_o = led_q;

endmodule

`default_nettype wire

// File: rtl/led_fade_pwm.sv
// ----------------------------------------------------------------------------
// led_fade_pwm : shared PWM timebase and decay prescaler driving N fade channels
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module led_fade_pwm
   import led_fade_pwm_pkg::*;
#(
   parameter int unsigned N_LED        = C_N_LED,
   parameter int unsigned PWM_BITS     = C_PWM_BITS,
   parameter int unsigned DECAY_FRAMES = C_DECAY_FRAMES,
   parameter int unsigned DECAY_STEP   = C_DECAY_STEP,
   parameter int unsigned ACTIVE_LOW   = C_ACTIVE_LOW
) (
   input  logic          clk,
   input  logic          rst,
   led_fade_pwm_if.slave bus
);

   localparam int unsigned          c_dcnt_w    = clog2_min1(DECAY_FRAMES);
   localparam logic [PWM_BITS-1:0]  c_max       = '1;
   localparam logic [c_dcnt_w-1:0]  c_dcnt_last = c_dcnt_w'(DECAY_FRAMES - 1);

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [c_dcnt_w-1:0] decay_cnt_q, decay_cnt_d;
   logic                frame_q, frame_d;
   logic                pwm_wrap;
   logic                decay_tick;
   logic [N_LED-1:0]    led_vec;

   always_comb begin
      pwm_wrap    = (pwm_cnt_q == c_max);
      decay_tick  = pwm_wrap && (decay_cnt_q == c_dcnt_last);
      pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
      decay_cnt_d = decay_cnt_q;
      if (pwm_wrap) begin
         decay_cnt_d = decay_tick ? '0 : decay_cnt_q + c_dcnt_w'(1);
      end
      frame_d = pwm_wrap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q   <= '0;
         decay_cnt_q <= '0;
         frame_q     <= 1'b0;
      end else begin
         pwm_cnt_q   <= pwm_cnt_d;
         decay_cnt_q <= decay_cnt_d;
         frame_q     <= frame_d;
      end
   end

   for (genvar i = 0; i < N_LED; i++) begin : g_channel
      led_fade_channel #(
         .PWM_BITS   (PWM_BITS),
         .DECAY_STEP (DECAY_STEP),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_channel (
         .clk          (clk),
         .rst          (rst),
         .pattern_i    (bus.pattern_i[i]),
         .en_i         (bus.en_i),
         .pwm_cnt_i    (pwm_cnt_q),
         .pwm_wrap_i   (pwm_wrap),
         .decay_tick_i (decay_tick),
         .led_o        (led_vec[i])
      );
   end

   assign bus.led_o   = led_vec;
   assign bus.frame_o = frame_q;

endmodule

`default_nettype wire
